// File: rtl/uart_prog_loader.sv
// uart_prog_loader: 8N1 UART image receiver that writes big-endian words into the instruction ROM
// Ports: clk, RST (async active-low); rx serial in; rom_we/rom_addr/rom_wdata ROM write port;
// cpu_rst_n holds the CPU in reset while loading or after a failed load; busy/done/err load status.
module uart_prog_loader #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int BAUD         = 115200,
  parameter int ADDR_W       = 8,
  parameter int MAX_WORDS    = 64,
  parameter int TIMEOUT_CLKS = 10*CLK_HZ/100
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              rx,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [31:0]       rom_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int CPB = CLK_HZ/BAUD;
  localparam int CW  = $clog2(CPB);
  localparam int IW  = ADDR_W-2;
  localparam int TW  = $clog2(TIMEOUT_CLKS+1);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_t;
  typedef enum logic [2:0] {L_IDLE, L_CNT, L_DATA, L_SUM, L_DONE, L_ERR} ld_t;
  rx_t           rs, rs_n;
  ld_t           ls, ls_n;
  logic [1:0]    sync;
  logic          rx_s, rx_d, tick, tick_h, byte_valid, frame_err;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_i;
  logic [7:0]    sh, sum;
  logic [IW:0]   n, idx;
  logic [1:0]    bcnt;
  logic [23:0]   word;
  logic [TW-1:0] gap;
  logic          active, wlast, timeout;
  assign rx_s   = sync[1];
  assign tick_h = cnt == CW'(CPB/2-1);
  assign tick   = cnt == CW'(CPB-1);
  always_comb begin
    rs_n       = rs;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rs)
      RX_IDLE:  rs_n = (rx_d & ~rx_s) ? RX_START : RX_IDLE;
      RX_START: if (tick_h) rs_n = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && bit_i == 3'd7) rs_n = RX_STOP;
      default: if (tick) begin
        rs_n       = RX_IDLE;
        byte_valid = rx_s;
        frame_err  = ~rx_s;
      end
    endcase
  end
  // cnt restarts on every state change so each phase times from its own entry
  always_ff @(posedge clk or negedge RST)
    if (!RST) begin
      sync  <= 2'b11;
      rx_d  <= 1'b1;
      rs    <= RX_IDLE;
      cnt   <= '0;
      bit_i <= '0;
      sh    <= '0;
    end else begin
      sync <= {sync[0], rx};
      rx_d <= rx_s;
      rs   <= rs_n;
      cnt  <= (rs_n != rs || tick) ? '0 : cnt + 1'b1;
      if (rs == RX_DATA && tick) begin
        sh    <= {rx_s, sh[7:1]};
        bit_i <= bit_i + 1'b1;
      end
    end
  assign active    = ls inside {L_CNT, L_DATA, L_SUM};
  assign wlast     = byte_valid && ls == L_DATA && bcnt == 2'd3;
  assign timeout   = active && !byte_valid && gap == TW'(TIMEOUT_CLKS-1);
  assign busy      = active;
  assign done      = ls == L_DONE;
  assign err       = ls == L_ERR;
  assign cpu_rst_n = !(active || err);
  always_comb begin
    ls_n = ls;
    case (ls)
      L_CNT:  if (byte_valid) ls_n = (sh == 8'd0 || int'(sh) > MAX_WORDS) ? L_ERR : L_DATA;
      L_DATA: if (wlast && idx + 1'b1 == n) ls_n = L_SUM;
      L_SUM:  if (byte_valid) ls_n = sh == sum ? L_DONE : L_ERR;
      default: if (byte_valid && sh == 8'hA5) ls_n = L_CNT;
    endcase
    if (active && (frame_err || timeout)) ls_n = L_ERR;
  end
  // the write strobe is registered, so it lands the cycle after the 4th byte of a word
  always_ff @(posedge clk or negedge RST)
    if (!RST) begin
      ls        <= L_IDLE;
      rom_we    <= 1'b0;
      rom_addr  <= '0;
      rom_wdata <= '0;
      n         <= '0;
      idx       <= '0;
      bcnt      <= '0;
      sum       <= '0;
      word      <= '0;
      gap       <= '0;
    end else begin
      ls     <= ls_n;
      rom_we <= wlast;
      gap    <= (byte_valid || !active) ? '0 : gap + 1'b1;
      if (ls == L_CNT && byte_valid) begin
        n    <= (IW+1)'(sh);
        idx  <= '0;
        bcnt <= '0;
        sum  <= '0;
      end
      if (ls == L_DATA && byte_valid) begin
        word <= {word[15:0], sh};
        sum  <= sum + sh;
        bcnt <= bcnt + 1'b1;
      end
      if (wlast) begin
        rom_addr  <= {idx[IW-1:0], 2'b00};
        rom_wdata <= {word, sh};
        idx       <= idx + 1'b1;
      end
    end
endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: scoreboard bench driving framed UART images into uart_prog_loader
module tb_uart_prog_loader;
  localparam int CPB = 10;
  localparam int TO  = 2000;
  logic        clk = 1'b0, RST = 1'b0, rx = 1'b1;
  logic        rom_we, cpu_rst_n, busy, done, err;
  logic [7:0]  rom_addr;
  logic [31:0] rom_wdata;
  int checks = 0, errors = 0;
  typedef struct packed {logic [7:0] a; logic [31:0] d;} wr_t;
  wr_t exp_q[$];
  wr_t e;
  logic [7:0] seq[$];
  uart_prog_loader #(.CLK_HZ(1_000_000), .BAUD(100_000), .ADDR_W(8), .MAX_WORDS(64),
                     .TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .RST(RST), .rx(rx), .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err));
  always #5 clk = ~clk;
  always @(negedge clk)
    if (RST && rom_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", rom_addr, rom_wdata);
      end else begin
        e = exp_q.pop_front();
        if (rom_addr != e.a || rom_wdata != e.d) begin
          errors++;
          $display("FAIL rom_write: got addr=%h data=%h, required addr=%h data=%h",
                   rom_addr, rom_wdata, e.a, e.d);
        end
      end
    end
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask
  task automatic status(input string name, input logic [3:0] exp);
    repeat (4) @(negedge clk);
    check(name, {busy, done, err, cpu_rst_n}, exp);
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask
  task automatic send_seq();
    foreach (seq[i]) send_byte(seq[i]);
  endtask
  task automatic glitch();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (2*CPB) @(negedge clk);
  endtask
  task automatic good_load();
    exp_q.push_back({8'h00, 32'h12345678});
    exp_q.push_back({8'h04, 32'h9ABCDEF0});
    seq = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    send_seq();
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1 ms, required completion");
    $fatal(1);
  end
  initial begin
    int j;
    repeat (3) @(negedge clk);
    check("reset_values", {rom_we, rom_addr, rom_wdata, busy, done, err, cpu_rst_n},
          {1'b0, 8'h00, 32'h0, 4'b0001});
    RST = 1'b1;
    repeat (5) @(negedge clk);
    seq = '{8'h00, 8'hFF};
    send_seq();
    status("idle_ignore", 4'b0001);
    good_load();
    status("pre_checksum", 4'b1000);
    send_byte(8'h38);
    status("good_load", 4'b0101);
    check("good_writes", exp_q.size(), 0);
    good_load();
    send_byte(8'h39);
    status("bad_checksum", 4'b0010);
    check("bad_writes", exp_q.size(), 0);
    good_load();
    send_byte(8'h38);
    status("reload_good", 4'b0101);
    seq = '{8'hA5};
    send_seq();
    status("restart_busy", 4'b1000);
    send_byte(8'h00);
    status("n_zero", 4'b0010);
    seq = '{8'hA5, 8'h41};
    send_seq();
    status("n_too_big", 4'b0010);
    seq = '{8'hA5, 8'h40};
    send_seq();
    status("n_max_ok", 4'b1000);
    send_byte(8'h55, 1'b0);
    status("frame_err", 4'b0010);
    seq = '{8'hA5, 8'h01, 8'h11, 8'h22, 8'h33};
    send_seq();
    j = 0;
    while (!err && j < 3*TO) begin
      @(negedge clk);
      j++;
    end
    check("timeout_clks", j, TO-2);
    good_load();
    send_byte(8'h38);
    glitch();
    status("glitch_idle", 4'b0101);
    exp_q.push_back({8'h00, 32'h01020304});
    seq = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_seq();
    repeat (3) @(negedge clk);
    RST = 1'b0;
    @(negedge clk);
    check("mid_reset", {rom_we, rom_addr, rom_wdata, busy, done, err, cpu_rst_n},
          {1'b0, 8'h00, 32'h0, 4'b0001});
    check("mid_reset_writes", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    RST = 1'b1;
    repeat (5) @(negedge clk);
    exp_q.push_back({8'h00, 32'h01020304});
    exp_q.push_back({8'h04, 32'hA5060708});
    exp_q.push_back({8'h08, 32'h090A0B0C});
    exp_q.push_back({8'h0C, 32'h0D0E0F10});
    seq = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA5, 8'h06};
    send_seq();
    glitch();
    seq = '{8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h28};
    send_seq();
    status("n4_load", 4'b0101);
    check("n4_writes", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
